eth_rx_frame_buffer: RTL and testbench
======================================

// Module: eth_rx_frame_buffer
// PURPOSE
//  Reader end of the Ethernet DMA controller's receive pipe. Consumes the word stream the
//  controller pushes out, validates each frame (error flag, length bounds) and stores good
//  frames in a two-entry ping-pong frame memory. A single consumer (CPU-side DMA/IO thread)
//  reads frames in arrival order over a random-access word port. The receive pipe has no backpressure, so
//  frames with no free buffer are dropped and counted.
// PARAMETERS
//  FRAME_WORDS  384  32-bit words per frame buffer (1536 B); ADDRW = $clog2(FRAME_WORDS)
//  MIN_BYTES    60   shorter committed frames are runts -> discarded, err_cnt++
//  CNTW         16   width of drop/error counters
// PORTS
//  clk             in   1          ring clock (gclk.clk domain)
//  reset           in   1          asynchronous, active-low
//  rx_valid        in   1          pipe word valid
//  rx_sof          in   1          first word of frame (qualified by rx_valid)
//  rx_eof          in   1          last word of frame (qualified by rx_valid)
//  rx_err          in   1          frame bad (CRC/PHY error); sampled only with rx_eof
//  rx_nbytes       in   2          valid bytes in eof word minus 1 (0 -> 1 B, 3 -> 4 B)
//  rx_data         in   32         pipe data, byte 0 in [31:24]
//  rd_frame_avail  out  1          oldest committed frame ready to read
//  rd_len          out  11         byte length of that frame
//  rd_addr         in   ADDRW      word address within current read frame
//  rd_data         out  32         frame word; 1-cycle registered read latency
//  rd_release      in   1          consumer done; frees current read buffer
//  drop_cnt        out  CNTW       frames dropped for lack of buffer (saturating)
//  err_cnt         out  CNTW       frames discarded: rx_err, runt, overflow, truncated (saturating)
// BEHAVIOUR
//  Reset (reset==0): all outputs 0; full[1:0]=0, wr_buf=rd_buf=0, FSM->IDLE. Memory not cleared.
//  Reset mid-frame discards it; later words lacking rx_sof are ignored.
//  Write FSM states IDLE, RECV, DROP; wcnt counts words written into wr_buf.
//   IDLE: rx_valid&rx_sof: if !full[wr_buf] -> write word at 0, wcnt=1, RECV; else drop_cnt++,
//     DROP. sof&eof together = one-word frame, evaluated immediately (commit rules below), stay IDLE.
//     rx_valid without sof ignored.
//   RECV: rx_valid&!rx_sof: if wcnt==FRAME_WORDS -> overflow, err_cnt++, DROP (unless eof -> IDLE);
//     else write at wcnt, wcnt++. rx_valid&rx_sof: truncated frame, err_cnt++, restart at word 0 of
//     same wr_buf.
//   On eof word (after writing it): len=(wcnt_final-1)*4+rx_nbytes+1. If rx_err or len<MIN_BYTES
//     -> err_cnt++, buffer stays free; else commit: full[wr_buf]=1, len stored, wr_buf toggles. -> IDLE.
//   DROP: ignore words until rx_valid&rx_eof -> IDLE. rx_valid&rx_sof in DROP handled as in IDLE.
//  Commit visible next cycle: rd_frame_avail=full[rd_buf], rd_len=len[rd_buf] (0 when !avail).
//  rd_release with avail: full[rd_buf]=0, rd_buf toggles next cycle; release when !avail ignored.
//  Commit and release in same cycle both take effect (different buffers by construction).
//  Buffers fill/drain alternately -> strict arrival order; at most 2 frames pending.
//  rd_data registered from mem[{rd_buf,rd_addr}] each cycle regardless of avail; rd_addr beyond
//   the frame returns stale contents; reads never stall writes (dual-port memory).
//  Counters saturate at all-ones; never wrap.
// TESTING
//  1. 64 B good frame (16 words, nbytes=3) -> avail=1 one cycle after eof, rd_len=64, words read back
//     at addr 0..15 with 1-cycle latency.
//  2. 3 back-to-back 100 B frames, no release -> frames 1,2 stored, frame 3 drop_cnt=1; release
//     twice -> lens 100,100 in order, avail=0.
//  3. Frame with rx_err at eof, then 40 B runt -> err_cnt=2, avail stays 0.
//  4. 1600 B frame (400 words) -> err_cnt=1 at word 385, buffer stays free; next 64 B frame commits.
//  5. sof mid-frame after 10 words then 80 B good frame -> err_cnt=1, rd_len=80, data from new frame.
//  6. Reset asserted mid-frame, then tail words without sof, then good 64 B frame -> only that frame
//     stored; counters 0; release and commit same cycle -> avail stays 1, next frame presented.

Source files
------------

// File: rtl/eth_rx_frame_buffer.sv
// eth_rx_frame_buffer
//   Receive side of the Ethernet DMA pipe. Accepts the controller's word stream,
//   validates each frame (error flag, runt length, overflow, truncation) and keeps
//   good frames in a two-entry ping-pong memory. One consumer reads frames in
//   arrival order through a random-access word port and releases them when done.
//   The pipe cannot be stalled: a frame that finds no free buffer is dropped.
//
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   rx_valid/sof/eof/err/nbytes/data   incoming word stream (byte 0 in [31:24])
//   rd_frame_avail  oldest committed frame is ready
//   rd_len          byte length of that frame (0 when none)
//   rd_addr         word address inside the current read frame
//   rd_data         registered read data, one cycle after rd_addr
//   rd_release      consumer is finished with the current frame
//   drop_cnt        frames dropped for lack of a buffer (saturating)
//   err_cnt         frames discarded as bad (saturating)
module eth_rx_frame_buffer #(
   parameter int FRAME_WORDS = 384,
   parameter int MIN_BYTES   = 60,
   parameter int CNTW        = 16,
   parameter int ADDRW       = $clog2(FRAME_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic             rx_err,
   input  logic [1:0]       rx_nbytes,
   input  logic [31:0]      rx_data,
   output logic             rd_frame_avail,
   output logic [10:0]      rd_len,
   input  logic [ADDRW-1:0] rd_addr,
   output logic [31:0]      rd_data,
   input  logic             rd_release,
   output logic [CNTW-1:0]  drop_cnt,
   output logic [CNTW-1:0]  err_cnt
);

   // word counter must be able to hold FRAME_WORDS itself
   localparam int WCW = ADDRW + 1;

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t           state, state_nxt;
   logic [WCW-1:0]   wcnt, wcnt_nxt;
   logic             wr_buf, rd_buf;
   logic [1:0]       full;
   logic [10:0]      len_q [2];
   logic [31:0]      mem [0:(2**(ADDRW+1))-1];

   logic             we;
   logic [ADDRW-1:0] waddr;
   logic             eval;        // eof word accepted into a buffer this cycle
   logic [WCW-1:0]   eval_words;  // word count of the frame being evaluated
   logic             err_fsm;     // overflow or truncation this cycle
   logic             drop_inc;
   logic [10:0]      frame_len;
   logic             eval_bad;
   logic             commit;
   logic             release_ok;
   logic [1:0]       err_add;
   logic [CNTW:0]    err_sum;
   logic [CNTW:0]    drop_sum;

   //-------------------------------------------------------------------------
   // Write FSM: state register
   //-------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   //-------------------------------------------------------------------------
   // Write FSM: next state, memory write and event decode
   //-------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      wcnt_nxt   = wcnt;
      we         = 1'b0;
      waddr      = '0;
      eval       = 1'b0;
      eval_words = '0;
      err_fsm    = 1'b0;
      drop_inc   = 1'b0;
      case (state)
         IDLE, DROP: begin
            if (rx_valid && rx_sof) begin
               if (!full[wr_buf]) begin
                  we       = 1'b1;
                  wcnt_nxt = WCW'(1);
                  if (rx_eof) begin
                     // single-word frame: judged on the spot
                     eval       = 1'b1;
                     eval_words = WCW'(1);
                     state_nxt  = IDLE;
                  end else begin
                     state_nxt = RECV;
                  end
               end else begin
                  drop_inc  = 1'b1;
                  state_nxt = rx_eof ? IDLE : DROP;
               end
            end else if (state == DROP && rx_valid && rx_eof) begin
               state_nxt = IDLE;
            end
         end
         RECV: begin
            if (rx_valid) begin
               if (rx_sof) begin
                  // previous frame never saw eof; restart in the same buffer,
                  // which is known to be free since we entered RECV on it
                  err_fsm  = 1'b1;
                  we       = 1'b1;
                  wcnt_nxt = WCW'(1);
                  if (rx_eof) begin
                     eval       = 1'b1;
                     eval_words = WCW'(1);
                     state_nxt  = IDLE;
                  end
               end else if (wcnt == WCW'(FRAME_WORDS)) begin
                  err_fsm   = 1'b1;
                  state_nxt = rx_eof ? IDLE : DROP;
               end else begin
                  we       = 1'b1;
                  waddr    = wcnt[ADDRW-1:0];
                  wcnt_nxt = wcnt + WCW'(1);
                  if (rx_eof) begin
                     eval       = 1'b1;
                     eval_words = wcnt + WCW'(1);
                     state_nxt  = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // byte length: full words before the eof word plus its valid bytes
   assign frame_len  = 11'((32'(eval_words) - 32'd1) * 32'd4 + 32'(rx_nbytes) + 32'd1);
   assign eval_bad   = rx_err || (frame_len < 11'(MIN_BYTES));
   assign commit     = eval && !eval_bad;
   assign release_ok = rd_release && full[rd_buf];
   // a truncation restart can coincide with a bad one-word frame: two errors
   assign err_add    = {1'b0, err_fsm} + {1'b0, eval && eval_bad};
   assign err_sum    = {1'b0, err_cnt} + {{(CNTW-1){1'b0}}, err_add};
   assign drop_sum   = {1'b0, drop_cnt} + {{CNTW{1'b0}}, 1'b1};

   //-------------------------------------------------------------------------
   // Buffer ownership, lengths and counters
   //-------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full     <= 2'b00;
         wr_buf   <= 1'b0;
         rd_buf   <= 1'b0;
         len_q[0] <= '0;
         len_q[1] <= '0;
         drop_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         // commit and release always address different buffers: commit needs
         // full[wr_buf]==0, release needs full[rd_buf]==1
         if (commit) begin
            full[wr_buf]  <= 1'b1;
            len_q[wr_buf] <= frame_len;
            wr_buf        <= ~wr_buf;
         end
         if (release_ok) begin
            full[rd_buf] <= 1'b0;
            rd_buf       <= ~rd_buf;
         end
         if (drop_inc)
            drop_cnt <= drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
         if (err_add != 2'd0)
            err_cnt <= err_sum[CNTW] ? '1 : err_sum[CNTW-1:0];
      end
   end

   //-------------------------------------------------------------------------
   // Frame memory: write port from the pipe, registered read port
   //-------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (we)
         mem[{wr_buf, waddr}] <= rx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_data <= '0;
      else
         rd_data <= mem[{rd_buf, rd_addr}];
   end

   assign rd_frame_avail = full[rd_buf];
   assign rd_len         = full[rd_buf] ? len_q[rd_buf] : 11'd0;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Self-checking bench for eth_rx_frame_buffer. A frame-level reference model
// (queue of pending frames, their lengths and words, plus counters) predicts
// what the consumer side must present after each directed or random step.
module tb_eth_rx_frame_buffer;
   localparam int FW = 384;
   localparam int AW = 9;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, rx_err = 1'b0;
   logic [1:0]    rx_nbytes = 2'd0;
   logic [31:0]   rx_data = '0;
   logic          rd_frame_avail;
   logic [10:0]   rd_len;
   logic [AW-1:0] rd_addr = '0;
   logic [31:0]   rd_data;
   logic          rd_release = 1'b0;
   logic [CW-1:0] drop_cnt, err_cnt;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [31:0] wq[$];   // words of pending frames, oldest first
   int          lq[$];   // byte lengths of pending frames
   int          nq[$];   // word counts of pending frames
   int          m_drop = 0;
   int          m_err  = 0;
   bit          m_open = 0;  // a frame was started in a buffer and not ended

   always #5 clk = ~clk;

   eth_rx_frame_buffer #(.FRAME_WORDS(FW), .MIN_BYTES(60), .CNTW(CW)) dut (
      .clk(clk), .reset(reset),
      .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
      .rx_nbytes(rx_nbytes), .rx_data(rx_data),
      .rd_frame_avail(rd_frame_avail), .rd_len(rd_len), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_release(rd_release),
      .drop_cnt(drop_cnt), .err_cnt(err_cnt)
   );

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; rd_release = 1'b0;
   endtask

   task automatic model_pop();
      int n;
      void'(lq.pop_front());
      n = nq.pop_front();
      repeat (n) void'(wq.pop_front());
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      wq.delete(); lq.delete(); nq.delete();
      m_drop = 0; m_err = 0; m_open = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_avail", 32'(rd_frame_avail), 32'd0);
      chk("rst_len",   32'(rd_len), 32'd0);
      chk("rst_data",  rd_data, 32'd0);
      chk("rst_drop",  32'(drop_cnt), 32'd0);
      chk("rst_err",   32'(err_cnt), 32'd0);
      reset = 1'b1;
   endtask

   task automatic chk_counters();
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("err_cnt",  32'(err_cnt),  32'(m_err));
   endtask

   // drive one word, with optional idle gaps carrying noise on sof/eof
   task automatic drive_word(input bit gaps, input bit sof, input bit eof,
                             input bit ferr, input int nb, input logic [31:0] d);
      @(negedge clk);
      while (gaps && $urandom_range(0, 3) == 0) begin
         rx_valid = 1'b0; rx_sof = 1'($urandom); rx_eof = 1'($urandom);
         @(negedge clk);
      end
      rx_valid  = 1'b1;
      rx_sof    = sof;
      rx_eof    = eof;
      rx_err    = eof ? ferr : 1'($urandom);
      rx_nbytes = eof ? 2'(nb) : 2'($urandom);
      rx_data   = d;
   endtask

   task automatic send_frame(input int nw, input int nb, input bit ferr,
                             input bit rel_eof, input bit gaps);
      logic [31:0] d[$];
      int len;
      bit had;
      had = lq.size() > 0;
      if (m_open) begin m_err++; m_open = 0; end
      len = (nw - 1) * 4 + nb + 1;
      for (int i = 0; i < nw; i++) d.push_back($urandom);
      if (lq.size() >= 2) m_drop++;
      else if (nw > FW) m_err++;
      else if (ferr || len < 60) m_err++;
      else begin
         lq.push_back(len); nq.push_back(nw);
         foreach (d[i]) wq.push_back(d[i]);
      end
      for (int i = 0; i < nw; i++) begin
         drive_word(gaps, i == 0, i == nw - 1, ferr, nb, d[i]);
         if (i == nw - 1 && rel_eof) rd_release = 1'b1;
      end
      @(negedge clk);
      idle_inputs();
      if (rel_eof && had) model_pop();
   endtask

   task automatic send_partial(input int nw);
      if (m_open) m_err++;
      else begin
         m_open = lq.size() < 2;
         if (!m_open) m_drop++;
      end
      for (int i = 0; i < nw; i++) drive_word(1'b0, i == 0, 1'b0, 1'b0, 0, $urandom);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic check_head();
      if (lq.size() == 0) begin
         chk("avail_empty", 32'(rd_frame_avail), 32'd0);
         chk("len_empty",   32'(rd_len), 32'd0);
      end else begin
         chk("avail", 32'(rd_frame_avail), 32'd1);
         chk("rd_len", 32'(rd_len), 32'(lq[0]));
         rd_addr = '0;
         for (int i = 0; i < nq[0]; i++) begin
            @(negedge clk);
            chk($sformatf("rd_data[%0d]", i), rd_data, wq[i]);
            rd_addr = AW'(i + 1);
         end
      end
   endtask

   task automatic release_frame();
      @(negedge clk);
      rd_release = 1'b1;
      @(negedge clk);
      rd_release = 1'b0;
      if (lq.size() > 0) model_pop();
   endtask

   initial begin
      // T1: 64 B frame, visible right after eof, read back in order
      do_reset();
      chk("t1_pre_avail", 32'(rd_frame_avail), 32'd0);
      send_frame(16, 3, 0, 0, 0);
      chk("t1_avail", 32'(rd_frame_avail), 32'd1);
      chk("t1_len", 32'(rd_len), 32'd64);
      check_head();
      chk_counters();
      release_frame();
      check_head();

      // T2: three 100 B frames, third one dropped
      do_reset();
      repeat (3) send_frame(25, 3, 0, 0, 1);
      chk("t2_drop", 32'(drop_cnt), 32'd1);
      chk_counters();
      check_head(); release_frame();
      check_head(); release_frame();
      check_head();

      // T3: errored frame then 40 B runt
      do_reset();
      send_frame(20, 3, 1, 0, 1);
      send_frame(10, 3, 0, 0, 1);
      chk("t3_err", 32'(err_cnt), 32'd2);
      chk_counters();
      check_head();

      // T4: 400-word overflow, then a good frame
      do_reset();
      send_frame(400, 3, 0, 0, 0);
      chk("t4_err", 32'(err_cnt), 32'd1);
      check_head();
      send_frame(16, 3, 0, 0, 0);
      chk_counters();
      check_head(); release_frame();

      // T5: truncated frame, then 80 B frame in the same buffer
      do_reset();
      send_partial(10);
      send_frame(20, 3, 0, 0, 1);
      chk("t5_err", 32'(err_cnt), 32'd1);
      chk("t5_len", 32'(rd_len), 32'd80);
      check_head(); release_frame();

      // T6: reset mid-frame, orphan tail ignored, then release+commit together
      do_reset();
      send_partial(5);
      do_reset();
      for (int i = 0; i < 4; i++) drive_word(1'b0, 1'b0, i == 3, 1'b0, 3, $urandom);
      @(negedge clk);
      idle_inputs();
      check_head();
      send_frame(16, 3, 0, 0, 0);
      chk("t6_drop", 32'(drop_cnt), 32'd0);
      chk("t6_err",  32'(err_cnt), 32'd0);
      check_head();
      send_frame(16, 0, 0, 1, 0);
      chk("t6_avail", 32'(rd_frame_avail), 32'd1);
      chk("t6_len", 32'(rd_len), 32'd61);
      check_head(); release_frame(); check_head();

      // boundaries: 60 B ok, 59 B runt, full-size, one word over, 1-word frame
      do_reset();
      send_frame(15, 3, 0, 0, 0);
      send_frame(15, 2, 0, 0, 0);
      chk_counters();
      check_head(); release_frame();
      send_frame(FW, 3, 0, 0, 0);
      chk("b_full_len", 32'(rd_len), 32'd1536);
      check_head(); release_frame();
      send_frame(FW + 1, 3, 0, 0, 0);
      send_frame(1, 3, 0, 0, 0);
      release_frame();
      chk_counters();
      check_head();

      // random traffic
      do_reset();
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 7) == 0) send_partial($urandom_range(1, 8));
         send_frame($urandom_range(1, 40), $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, 1'b0, 1'b1);
         chk_counters();
         repeat ($urandom_range(0, 2)) begin
            check_head();
            release_frame();
         end
         check_head();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
